// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    StPllRst    = 3'd0,
    StWaitLock  = 3'd1,
    StStableChk = 3'd2,
    StRun       = 3'd3,
    StFail      = 3'd4
  } pll_state_e;

  // Width of the shared phase counter: enough to reach the largest terminal count.
  function automatic int unsigned cnt_width(input int unsigned rst_pulse,
                                            input int unsigned lock_timeout,
                                            input int unsigned stable_cycles);
    int unsigned m;
    m = rst_pulse;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

  // Increment v, holding at the all-ones value of a w-bit field (1 <= w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] all_ones;
    all_ones = 32'hffff_ffff >> (32 - w);
    return (v == all_ones) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync.sv
// Two-flop synchronizer with synchronous active-high reset.
module bit_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Capture the asynchronous input, then re-register to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, waits for lock with timeout/retry, debounces lock and
// gates the downstream system reset request.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_PULSE     = 16,
  parameter int unsigned LOCK_TIMEOUT  = 100000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned LOSS_CNT_W    = 8
) (
  input  logic                             refclk,
  input  logic                             rst,
  input  logic                             pll_locked,
  output logic                             pll_rst,
  output logic                             sys_rst_req,
  output logic                             ready,
  output logic                             fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
  output logic [LOSS_CNT_W-1:0]            lock_loss_count
);

  localparam int unsigned CntW   = cnt_width(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

  localparam logic [CntW-1:0]   RstLast     = CntW'(RST_PULSE - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0]   StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRIES);

  pll_state_e             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [RetryW-1:0]      retry_q, retry_d;
  logic [RetryW-1:0]      retry_inc;
  logic [LOSS_CNT_W-1:0]  loss_q, loss_d;
  logic                   locked_s;

  bit_sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  assign retry_inc = retry_q + RetryW'(1);

  // Next-state logic; cnt is cleared on every state entry and counts up otherwise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      StPllRst: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        // A lock arriving on the timeout cycle takes precedence over the retry.
        if (locked_s) begin
          state_d = StStableChk;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RetryMax) ? StFail : StPllRst;
          cnt_d   = '0;
        end
      end
      StStableChk: begin
        if (!locked_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          retry_d = '0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = StPllRst;
          loss_d  = LOSS_CNT_W'(sat_inc(32'(loss_q), LOSS_CNT_W));
        end
      end
      StFail: begin
        cnt_d = '0;
      end
      default: begin
        state_d = StPllRst;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers; rst overrides every transition.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= StPllRst;
      cnt_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  assign pll_rst         = (state_q == StPllRst) || (state_q == StFail);
  assign sys_rst_req     = (state_q != StRun);
  assign ready           = (state_q == StRun);
  assign fail            = (state_q == StFail);
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed scoreboard bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_req;
  logic       ready;
  logic       fail;
  logic [1:0] retry_count;
  logic [1:0] lock_loss_count;

  pll_lock_supervisor #(
    .RST_PULSE     (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (3),
    .LOSS_CNT_W    (2)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .pll_rst         (pll_rst),
    .sys_rst_req     (sys_rst_req),
    .ready           (ready),
    .fail            (fail),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  cyc;
  int  tests;
  int  fails;

  // Queue an expected output vector d cycles from now.
  task automatic sb_push(input int d, input string tag, input logic pr, input logic sr,
                         input logic rd, input logic fl, input logic [1:0] rc,
                         input logic [1:0] lc);
    sb_t e;
    e.cyc = cyc + d;
    e.tag = tag;
    e.exp = {pr, sr, rd, fl, rc, lc};
    sb_q.push_back(e);
  endtask

  // Compare every entry due this cycle, then retire it.
  task automatic check_sb();
    logic [7:0] obs;
    obs = {pll_rst, sys_rst_req, ready, fail, retry_count, lock_loss_count};
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        tests++;
        assert (obs === sb_q[i].exp)
        else begin
          fails++;
          $error("FAIL %s cyc %0d: got {pr,sr,rdy,fail,retry,loss}=%b want %b",
                 sb_q[i].tag, cyc, obs, sb_q[i].exp);
        end
        sb_q.delete(i);
      end
    end
  endtask

  // Advance n clocks, sampling 1ns after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge refclk);
      #1;
      cyc++;
      check_sb();
    end
  endtask

  initial begin
    logic [1:0] li;
    cyc        = 0;
    tests      = 0;
    fails      = 0;
    rst        = 1'b1;
    pll_locked = 1'b0;

    // Reset, release, then lock from cycle 10.
    sb_push(1, "rst_hold1", 1, 1, 0, 0, 2'd0, 2'd0);
    sb_push(3, "rst_hold3", 1, 1, 0, 0, 2'd0, 2'd0);
    step(3);
    rst = 1'b0;
    sb_push(3, "t1_pllrst_last", 1, 1, 0, 0, 2'd0, 2'd0);
    sb_push(4, "t1_pllrst_drop", 0, 1, 0, 0, 2'd0, 2'd0);
    step(7);
    pll_locked = 1'b1;
    sb_push(10, "t1_pre_ready", 0, 1, 0, 0, 2'd0, 2'd0);
    sb_push(11, "t1_ready", 0, 0, 1, 0, 2'd0, 2'd0);
    step(11);

    // Four single-cycle lock drops in RUN; loss counter saturates at 3.
    for (int i = 0; i < 4; i++) begin
      li = (i >= 3) ? 2'd3 : 2'(i + 1);
      pll_locked = 1'b0;
      sb_push(2, "t4_still_run", 0, 0, 1, 0, 2'd0, 2'(i));
      sb_push(3, "t4_loss_react", 1, 1, 0, 0, 2'd0, li);
      step(1);
      pll_locked = 1'b1;
      sb_push(14, "t4_relock_chk", 0, 1, 0, 0, 2'd0, li);
      sb_push(15, "t4_rerun", 0, 0, 1, 0, 2'd0, li);
      step(19);
    end

    // Reset from RUN clears the loss counter; then lock interrupted in STABLE_CHK.
    rst = 1'b1;
    sb_push(1, "t6_rst_in_run", 1, 1, 0, 0, 2'd0, 2'd0);
    step(2);
    rst        = 1'b0;
    pll_locked = 1'b0;
    sb_push(15, "t3_no_early_ready", 0, 1, 0, 0, 2'd0, 2'd0);
    sb_push(20, "t3_pre_ready", 0, 1, 0, 0, 2'd0, 2'd0);
    sb_push(21, "t3_ready", 0, 0, 1, 0, 2'd0, 2'd0);
    step(4);
    pll_locked = 1'b1;
    step(5);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(12);

    // Lock seen on the last WAIT_LOCK cycle beats the timeout.
    rst = 1'b1;
    step(1);
    rst        = 1'b0;
    pll_locked = 1'b0;
    sb_push(23, "t5_wait_last", 0, 1, 0, 0, 2'd0, 2'd0);
    sb_push(24, "t5_lock_wins", 0, 1, 0, 0, 2'd0, 2'd0);
    sb_push(31, "t5_pre_ready", 0, 1, 0, 0, 2'd0, 2'd0);
    sb_push(32, "t5_ready", 0, 0, 1, 0, 2'd0, 2'd0);
    step(21);
    pll_locked = 1'b1;
    step(12);

    // Reset while in STABLE_CHK.
    rst = 1'b1;
    step(1);
    rst        = 1'b0;
    pll_locked = 1'b1;
    sb_push(7, "t6_in_stable", 0, 1, 0, 0, 2'd0, 2'd0);
    step(7);
    rst = 1'b1;
    sb_push(1, "t6_rst_stable", 1, 1, 0, 0, 2'd0, 2'd0);
    step(1);

    // No lock at all: three timeouts, then terminal FAIL.
    pll_locked = 1'b0;
    step(1);
    rst = 1'b0;
    sb_push(3,   "t2_pulse1_end", 1, 1, 0, 0, 2'd0, 2'd0);
    sb_push(4,   "t2_wait1",      0, 1, 0, 0, 2'd0, 2'd0);
    sb_push(23,  "t2_wait1_last", 0, 1, 0, 0, 2'd0, 2'd0);
    sb_push(24,  "t2_retry1",     1, 1, 0, 0, 2'd1, 2'd0);
    sb_push(27,  "t2_pulse2_end", 1, 1, 0, 0, 2'd1, 2'd0);
    sb_push(28,  "t2_wait2",      0, 1, 0, 0, 2'd1, 2'd0);
    sb_push(48,  "t2_retry2",     1, 1, 0, 0, 2'd2, 2'd0);
    sb_push(71,  "t2_wait3_last", 0, 1, 0, 0, 2'd2, 2'd0);
    sb_push(72,  "t2_fail",       1, 1, 0, 1, 2'd3, 2'd0);
    sb_push(100, "t2_fail_hold",  1, 1, 0, 1, 2'd3, 2'd0);
    step(75);
    pll_locked = 1'b1;
    step(25);

    // Reset out of FAIL clears everything and restarts the sequence.
    rst = 1'b1;
    sb_push(1, "t6_rst_fail", 1, 1, 0, 0, 2'd0, 2'd0);
    step(1);
    rst        = 1'b0;
    pll_locked = 1'b0;
    sb_push(4, "t6_restart", 0, 1, 0, 0, 2'd0, 2'd0);
    step(5);

    foreach (sb_q[i]) begin
      tests++;
      fails++;
      $display("FAIL %s never checked: got none want %b at cyc %0d",
               sb_q[i].tag, sb_q[i].exp, sb_q[i].cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
